// File: rtl/bpc_pkg.sv
// Shared types and sizing helpers for the bit population counter family.
package bpc_pkg;

  typedef enum logic {
    BPC_MODE_ONES  = 1'b0,
    BPC_MODE_ZEROS = 1'b1
  } bpc_mode_e;

  // Width of a count able to represent 0..width inclusive.
  function automatic int unsigned bpc_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Leaf stage plus one registered level per adder-tree halving.
  function automatic int unsigned bpc_latency(input int unsigned width,
                                              input int unsigned chunk);
    return 1 + $clog2(width / chunk);
  endfunction

endpackage

// File: rtl/bpc_chunk_counter.sv
// Combinational popcount of one CHUNK-bit leaf slice.
module bpc_chunk_counter #(
  parameter int unsigned CHUNK = 8,
  localparam int unsigned CW   = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] data_i,
  output logic [CW-1:0]    cnt_o
);

  // Ripple sum of the slice bits.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      cnt_o = cnt_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/bit_population_counter_acc.sv
// Pipelined ones/zeros counter with a saturating per-packet accumulator.
module bit_population_counter_acc
  import bpc_pkg::*;
#(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned CHUNK     = 8,
  parameter int unsigned ACC_WIDTH = 16,
  localparam int unsigned CNT_W    = bpc_cnt_w(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 data_val_i,
  input  logic                 data_sop_i,
  input  logic                 data_eop_i,
  input  logic                 mode_i,
  output logic [CNT_W-1:0]     data_o,
  output logic                 data_val_o,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 acc_val_o,
  output logic                 acc_ovf_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned LEVELS = $clog2(NCHUNK);
  localparam int unsigned LAT    = bpc_latency(WIDTH, CHUNK);
  localparam int unsigned CW     = $clog2(CHUNK) + 1;
  localparam int unsigned TREE_W = CW + LEVELS;

  logic [LAT-1:0] vld_q, sop_q, eop_q;

  // Sideband delay line; index s is aligned with the data held in pipeline stage s.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      vld_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
    end else begin
      vld_q[0] <= data_val_i;
      sop_q[0] <= data_sop_i;
      eop_q[0] <= data_eop_i;
      for (int s = 1; s < int'(LAT); s++) begin
        vld_q[s] <= vld_q[s-1];
        sop_q[s] <= sop_q[s-1];
        eop_q[s] <= eop_q[s-1];
      end
    end
  end

  // Zero counting is ones counting on the inverted word.
  logic [WIDTH-1:0] data_sel;
  assign data_sel = (bpc_mode_e'(mode_i) == BPC_MODE_ZEROS) ? ~data_i : data_i;

  logic [CW-1:0] leaf_cnt [NCHUNK];
  logic [CW-1:0] leaf_q   [NCHUNK];

  for (genvar i = 0; i < NCHUNK; i++) begin : g_leaf
    bpc_chunk_counter #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .data_i (data_sel[i*CHUNK +: CHUNK]),
      .cnt_o  (leaf_cnt[i])
    );
  end

  // Stage 1: register leaf counts; stages only load on valid so the final one holds data_o.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      leaf_q <= '{default: '0};
    end else if (data_val_i) begin
      leaf_q <= leaf_cnt;
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N = NCHUNK >> l;
    localparam int unsigned W = CW + l;
    logic [W-1:0] sum_d [N];
    logic [W-1:0] sum_q [N];
    for (genvar j = 0; j < N; j++) begin : g_add
      if (l == 1) begin : g_first
        assign sum_d[j] = W'(leaf_q[2*j]) + W'(leaf_q[2*j+1]);
      end else begin : g_next
        assign sum_d[j] = W'(g_lvl[l-1].sum_q[2*j]) + W'(g_lvl[l-1].sum_q[2*j+1]);
      end
    end
    // Pairwise adder level, enabled by the valid entering it.
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        sum_q <= '{default: '0};
      end else if (vld_q[l-1]) begin
        sum_q <= sum_d;
      end
    end
  end

  logic [TREE_W-1:0] tree_out;
  if (LEVELS == 0) begin : g_no_tree
    assign tree_out = leaf_q[0];
  end else begin : g_tree
    assign tree_out = g_lvl[LEVELS].sum_q[0];
  end

  assign data_o     = CNT_W'(tree_out);
  assign data_val_o = vld_q[LAT-1];

  logic [ACC_WIDTH-1:0] run_q, run_d;
  logic                 run_ovf_q, run_ovf_d;
  logic                 after_eop_q;
  logic                 word_start;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 acc_ovf_q, acc_val_q;

  // First word after reset or after an eop starts a packet even without sop.
  assign word_start = sop_q[LAT-1] | after_eop_q;

  // Next running total: restart, saturate on carry-out, or plain add.
  always_comb begin
    acc_sum   = {1'b0, run_q} + (ACC_WIDTH+1)'(data_o);
    run_d     = acc_sum[ACC_WIDTH-1:0];
    run_ovf_d = run_ovf_q;
    if (word_start) begin
      run_d     = ACC_WIDTH'(data_o);
      run_ovf_d = 1'b0;
    end else if (acc_sum[ACC_WIDTH]) begin
      run_d     = '1;
      run_ovf_d = 1'b1;
    end
  end

  // Running total advances per counted word; published total only on eop.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      run_q       <= '0;
      run_ovf_q   <= 1'b0;
      after_eop_q <= 1'b1;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      acc_val_q   <= 1'b0;
    end else begin
      acc_val_q <= 1'b0;
      if (data_val_o) begin
        run_q       <= run_d;
        run_ovf_q   <= run_ovf_d;
        after_eop_q <= eop_q[LAT-1];
        if (eop_q[LAT-1]) begin
          acc_q     <= run_d;
          acc_ovf_q <= run_ovf_d;
          acc_val_q <= 1'b1;
        end
      end
    end
  end

  assign acc_o     = acc_q;
  assign acc_ovf_o = acc_ovf_q;
  assign acc_val_o = acc_val_q;

endmodule

// File: tb/tb_bit_population_counter_acc.sv
// Bench: two instances (16- and 8-bit accumulators) checked each cycle against a packet-level model.
module tb_bit_population_counter_acc;

  localparam int W   = 128;
  localparam int LAT = 5;

  logic           clk = 1'b0;
  logic           srst;
  logic [W-1:0]   data;
  logic           val, sop, eop, mode;

  logic [7:0]     d16_dout, d8_dout;
  logic           d16_dval, d8_dval;
  logic [15:0]    d16_acc;
  logic [7:0]     d8_acc;
  logic           d16_aval, d8_aval, d16_ovf, d8_ovf;

  bit_population_counter_acc u_dut16 (
    .clk_i      (clk),
    .srst_i     (srst),
    .data_i     (data),
    .data_val_i (val),
    .data_sop_i (sop),
    .data_eop_i (eop),
    .mode_i     (mode),
    .data_o     (d16_dout),
    .data_val_o (d16_dval),
    .acc_o      (d16_acc),
    .acc_val_o  (d16_aval),
    .acc_ovf_o  (d16_ovf)
  );

  bit_population_counter_acc #(
    .ACC_WIDTH (8)
  ) u_dut8 (
    .clk_i      (clk),
    .srst_i     (srst),
    .data_i     (data),
    .data_val_i (val),
    .data_sop_i (sop),
    .data_eop_i (eop),
    .mode_i     (mode),
    .data_o     (d8_dout),
    .data_val_o (d8_dval),
    .acc_o      (d8_acc),
    .acc_val_o  (d8_aval),
    .acc_ovf_o  (d8_ovf)
  );

  always #5 clk = ~clk;

  // Model state: words in flight with the cycle their count must appear.
  typedef struct {
    int cyc_due;
    int cnt;
    bit sop;
    bit eop;
  } beat_t;
  beat_t pipe[$];

  int  cyc = 0;
  int  n_tests = 0, n_fail = 0;
  bit  exp_dval, exp_aval, exp_ovf16, exp_ovf8;
  int  exp_dout, exp_acc16, exp_acc8;
  int  tot16, tot8;
  bit  movf16, movf8, prev_eop;
  bit  pend_aval;
  int  pend16, pend8;
  bit  pendo16, pendo8;

  // Observed DUT events for the directed literal checks.
  int  n_dval = 0, n_aval16 = 0, n_aval8 = 0;
  int  last_dout, last_dval_cyc, last_aval_cyc;
  int  last_acc16, last_acc8;
  bit  last_ovf16, last_ovf8;
  int  run_len = 0, max_run = 0;

  function automatic int model_count(input logic [W-1:0] w, input bit m);
    int ones = $countones(w);
    return m ? W - ones : ones;
  endfunction

  task automatic model_reset();
    pipe.delete();
    exp_dval = 0; exp_aval = 0; exp_dout = 0;
    exp_acc16 = 0; exp_acc8 = 0; exp_ovf16 = 0; exp_ovf8 = 0;
    tot16 = 0; tot8 = 0; movf16 = 0; movf8 = 0;
    prev_eop = 1; pend_aval = 0;
  endtask

  // Called just after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    beat_t b;
    if (srst) begin
      model_reset();
      cyc++;
      return;
    end
    exp_aval = pend_aval;
    if (pend_aval) begin
      exp_acc16 = pend16; exp_ovf16 = pendo16;
      exp_acc8  = pend8;  exp_ovf8  = pendo8;
    end
    pend_aval = 0;
    if (val) pipe.push_back('{cyc + LAT, model_count(data, mode), sop, eop});
    cyc++;
    exp_dval = 0;
    if (pipe.size() > 0 && pipe[0].cyc_due == cyc) begin
      b = pipe.pop_front();
      exp_dval = 1;
      exp_dout = b.cnt;
      if (b.sop || prev_eop) begin
        tot16 = b.cnt; movf16 = 0;
        tot8  = b.cnt; movf8  = 0;
      end else begin
        tot16 += b.cnt;
        tot8  += b.cnt;
        if (tot16 > 65535) begin tot16 = 65535; movf16 = 1; end
        if (tot8 > 255)    begin tot8  = 255;   movf8  = 1; end
      end
      prev_eop = b.eop;
      if (b.eop) begin
        pend_aval = 1;
        pend16 = tot16; pendo16 = movf16;
        pend8  = tot8;  pendo8  = movf8;
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    check("dut16.data_val_o", d16_dval, exp_dval);
    check("dut16.data_o", d16_dout, exp_dout);
    check("dut16.acc_val_o", d16_aval, exp_aval);
    check("dut16.acc_o", d16_acc, exp_acc16);
    check("dut16.acc_ovf_o", d16_ovf, exp_ovf16);
    check("dut8.data_val_o", d8_dval, exp_dval);
    check("dut8.data_o", d8_dout, exp_dout);
    check("dut8.acc_val_o", d8_aval, exp_aval);
    check("dut8.acc_o", d8_acc, exp_acc8);
    check("dut8.acc_ovf_o", d8_ovf, exp_ovf8);
    if (d16_dval) begin
      n_dval++; last_dout = d16_dout; last_dval_cyc = cyc;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (d16_aval) begin
      n_aval16++; last_acc16 = d16_acc; last_ovf16 = d16_ovf; last_aval_cyc = cyc;
    end
    if (d8_aval) begin
      n_aval8++; last_acc8 = d8_acc; last_ovf8 = d8_ovf;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Valid beat; the other inputs stay as given for exactly one cycle.
  task automatic beat(input logic [W-1:0] w, input bit m, input bit s, input bit e);
    val = 1; data = w; mode = m; sop = s; eop = e;
    step();
  endtask

  // Idle cycle with junk on the inputs that must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      val = 0; data = rand_word(); mode = $urandom_range(0, 1);
      sop = $urandom_range(0, 1); eop = $urandom_range(0, 1);
      step();
    end
  endtask

  logic [W-1:0] ones_w, half_w, w3;

  initial begin
    int d0, a0, c0;
    logic [W-1:0] sw [4];
    int           sc [4];
    bit           sm [4];

    ones_w = '1;
    half_w = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    w3     = 128'h3;
    model_reset();
    srst = 1; val = 1; data = ones_w; mode = 0; sop = 1; eop = 1;

    // Reset held with valid high, then released with valid low.
    for (int k = 0; k < 4; k++) begin
      data = rand_word();
      step();
    end
    srst = 0;
    idle(10);
    check("reset: no data_val_o", n_dval, 0);
    check("reset: no acc_val_o", n_aval16 + n_aval8, 0);
    check("reset: data_o", d16_dout, 0);
    check("reset: acc_o", d16_acc, 0);

    // Single-word packets with hand-computed counts.
    sw[0] = ones_w;  sm[0] = 0; sc[0] = 128;
    sw[1] = 128'h1;  sm[1] = 0; sc[1] = 1;
    sw[2] = '0;      sm[2] = 0; sc[2] = 0;
    sw[3] = 128'hFF; sm[3] = 1; sc[3] = 120;
    for (int t = 0; t < 4; t++) begin
      d0 = n_dval; a0 = n_aval16; c0 = cyc;
      beat(sw[t], sm[t], 1, 1);
      idle(7);
      check("single: data_val_o count", n_dval - d0, 1);
      check("single: data_o", last_dout, sc[t]);
      check("single: data latency", last_dval_cyc - c0, 5);
      check("single: acc_val_o count", n_aval16 - a0, 1);
      check("single: acc_o", last_acc16, sc[t]);
      check("single: acc latency", last_aval_cyc - c0, 6);
      check("single: acc8 acc_o", last_acc8, sc[t]);
    end

    // Back-to-back random words, random mode and random packet framing.
    d0 = n_dval; max_run = 0;
    for (int k = 0; k < 200; k++) begin
      logic [W-1:0] w;
      case ($urandom_range(0, 7))
        0:       w = ones_w;
        1:       w = '0;
        default: w = rand_word();
      endcase
      beat(w, $urandom_range(0, 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    idle(8);
    check("stream: data_val_o count", n_dval - d0, 200);
    check("stream: no bubbles", max_run, 200);

    // Four-word packet with a gap: 128 + 64 + 0 + 7.
    a0 = n_aval16;
    beat(ones_w, 0, 1, 0);
    beat(half_w, 0, 0, 0);
    idle(2);
    beat('0, 0, 0, 0);
    beat(128'h7F, 0, 0, 1);
    idle(8);
    check("packet: acc_val_o count", n_aval16 - a0, 1);
    check("packet: acc_o", last_acc16, 199);
    check("packet: acc_ovf_o", last_ovf16, 0);
    check("packet: acc8 acc_o", last_acc8, 199);

    // Saturation of the 8-bit accumulator, then a clean restart.
    beat(ones_w, 0, 1, 0);
    beat(ones_w, 0, 0, 0);
    beat(ones_w, 0, 0, 1);
    idle(8);
    check("sat: acc8 acc_o", last_acc8, 255);
    check("sat: acc8 acc_ovf_o", last_ovf8, 1);
    check("sat: acc16 acc_o", last_acc16, 384);
    check("sat: acc16 acc_ovf_o", last_ovf16, 0);
    beat(w3, 0, 1, 1);
    idle(8);
    check("after sat: acc8 acc_o", last_acc8, 2);
    check("after sat: acc8 acc_ovf_o", last_ovf8, 0);

    // Reset two cycles after the eop beat kills the whole packet.
    a0 = n_aval16; d0 = n_dval;
    beat(ones_w, 0, 1, 0);
    beat(ones_w, 0, 0, 0);
    beat(w3, 0, 0, 1);
    idle(1);
    srst = 1;
    idle(1);
    srst = 0;
    idle(8);
    check("mid reset: acc_val_o count", n_aval16 - a0, 0);
    check("mid reset: data_val_o count", n_dval - d0, 0);
    beat(w3, 0, 1, 1);
    idle(8);
    check("post reset: acc_o", last_acc16, 2);
    check("post reset: acc_val_o count", n_aval16 - a0, 1);

    // Mid-packet sop restarts the total; a word after eop starts a packet by itself.
    a0 = n_aval16;
    beat(ones_w, 0, 1, 0);
    beat(w3, 0, 1, 1);
    beat(128'hF, 0, 0, 1);
    idle(8);
    check("restart: acc_val_o count", n_aval16 - a0, 2);
    check("restart: acc_o", last_acc16, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
